branch_sequencer: RTL
=====================

Name: branch_sequencer

Overview:
- Moore control sequencer for the execute phase of conditional-branch instructions, steps T3..T6 (T0..T2 fetch is owned by the main control unit).
- Drives the bus/register strobes needed to:
  - evaluate the branch condition into the CON flip-flop;
  - compute PC + sign-extended offset in the ALU;
  - load the target into PC only when the condition holds.
- Sits between the main control unit (start/done handshake) and the datapath strobe lines.

Parameters:
- BR_OPCODE, 5'b10010, value of ir[31:27] that identifies a branch instruction.
- EARLY_EXIT, 1, when 1 a not-taken branch finishes right after T4 and skips T5/T6; when 0 every branch runs T3..T6.

Ports:
- clock  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high; returns the block to IDLE.
- start  input  1  one-cycle request from the main control unit; sampled only in IDLE.
- ir  input  32  instruction register contents; sampled on the accepted start.
- stall  input  1  freezes the sequencer (memory/bus wait).
- con  input  1  output of the CON flip-flop.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle completion pulse.
- illegal  output  1  qualifies done; opcode was not BR_OPCODE.
- taken  output  1  registered branch outcome of the last completed branch.
- gra  output  1  select Ra field for the register file.
- rout  output  1  drive the selected register onto the bus.
- con_in  output  1  CON flip-flop load enable.
- pc_out  output  1  drive PC onto the bus.
- y_in  output  1  load Y register.
- c_out  output  1  drive the sign-extended constant onto the bus.
- alu_add  output  1  ALU operation select = ADD.
- z_in  output  1  load Z register.
- zlow_out  output  1  drive Z[31:0] onto the bus.
- pc_in  output  1  load PC from the bus.

Behaviour:
- States: IDLE, T3, T4, T5, T6, DONE. Encoding is free; the state register resets to IDLE.
- All strobe outputs, busy, done and illegal are decoded from state only (Moore), gated by stall as specified below.
- In the cycle after reset is sampled high:
  - every strobe, busy, done and illegal is 0;
  - taken is 0.
- reset has priority over start and stall.
- A reset during any state returns to IDLE with no further strobes and no done pulse.
- Transitions:
  - IDLE -> T3 on start=1 when ir[31:27]==BR_OPCODE.
  - IDLE -> DONE with illegal latched 1 on start=1 when ir[31:27]!=BR_OPCODE.
  - T3 -> T4.
  - T4 -> T5, except: when EARLY_EXIT=1 and con=0, T4 -> DONE.
  - T5 -> T6.
  - T6 -> DONE.
  - DONE -> IDLE.
- Strobes per state (all others 0):
  - T3: gra, rout, con_in. The CON flip-flop captures on the T3->T4 edge, so con is valid from T4 onward.
  - T4: pc_out, y_in. taken_next = con, registered on the edge leaving T4.
  - T5: c_out, alu_add, z_in.
  - T6: zlow_out, plus pc_in only if taken==1.
  - DONE: done=1. illegal=1 if and only if the accepted opcode was not BR_OPCODE.
- Latency from start high in IDLE to done high:
  - taken, or EARLY_EXIT=0: 5 cycles.
  - not taken with EARLY_EXIT=1: 3 cycles.
  - illegal: 1 cycle.
- busy is high from the cycle after start is accepted through DONE inclusive.
- start while busy is ignored; it is not queued.
- stall=1 in T3..T6:
  - state holds;
  - all strobes are forced to 0 for that cycle;
  - taken does not update.
- When stall deasserts, the held state's strobes assert for exactly one cycle, so no register loads twice.
- stall is ignored in IDLE and DONE.
- illegal:
  - cleared on every accepted start;
  - otherwise holds its value until the next accepted start.
- taken:
  - holds its value until the next T4 capture;
  - on an illegal opcode it is not updated.
- A con change outside T4 has no effect.

Test Plan:
- Reset, then ir=32'h9008_0004 (opcode 10010), con=1, start one cycle, EARLY_EXIT=1 -> strobe sequence T3{gra,rout,con_in}, T4{pc_out,y_in}, T5{c_out,alu_add,z_in}, T6{zlow_out,pc_in}; done on cycle 5 after start; taken=1; illegal=0.
- Same ir with con=0, EARLY_EXIT=1 -> T3, T4, then done on cycle 3; pc_in never asserted; taken=0. Repeat with EARLY_EXIT=0 -> T5 and T6 run, T6 has zlow_out=1 and pc_in=0, done on cycle 5.
- stall high for 2 cycles upon entering T5 of a taken branch -> strobes all 0 during the stall; z_in high for exactly one cycle afterwards; done delayed to cycle 7; pc_in pulses once.
- start with ir[31:27]=5'b00011 -> next cycle state DONE: done=1, illegal=1, no strobes, taken unchanged; following cycle busy=0.
- Assert reset during T5 -> next cycle all outputs 0 and busy=0, no done pulse. A new start two cycles later executes a full branch normally.
- start pulses in T4 and in DONE -> ignored. Exactly one done per accepted start; the sequence is identical to the first scenario.

Source files
------------

// File: rtl/branch_sequencer.sv
// Moore sequencer for the execute steps T3..T6 of conditional branches.
// Drives the datapath strobes that test CON, form PC+offset and conditionally load PC.
module branch_sequencer #(
  parameter logic [4:0] BR_OPCODE  = 5'b10010,
  parameter bit         EARLY_EXIT = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] ir,
  input  logic        stall,
  input  logic        con,
  output logic        busy,
  output logic        done,
  output logic        illegal,
  output logic        taken,
  output logic        gra,
  output logic        rout,
  output logic        con_in,
  output logic        pc_out,
  output logic        y_in,
  output logic        c_out,
  output logic        alu_add,
  output logic        z_in,
  output logic        zlow_out,
  output logic        pc_in
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_T3   = 3'd1,
    S_T4   = 3'd2,
    S_T5   = 3'd3,
    S_T6   = 3'd4,
    S_DONE = 3'd5
  } state_t;

  state_t r_state;
  state_t w_next;
  logic   r_taken;
  logic   r_illegal;
  logic   w_is_branch;
  logic   w_unused_ir;

  assign w_is_branch = (ir[31:27] == BR_OPCODE);
  assign w_unused_ir = &{1'b0, ir[26:0]};

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Outcome is captured only on an unstalled exit from T4; illegal on every accepted start.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_taken   <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      if (r_state == S_T4 && !stall) begin
        r_taken <= con;
      end
      if (r_state == S_IDLE && start) begin
        r_illegal <= !w_is_branch;
      end
    end
  end

  assign taken   = r_taken;
  assign illegal = r_illegal;

  always_comb begin
    w_next   = r_state;
    busy     = (r_state != S_IDLE);
    done     = 1'b0;
    gra      = 1'b0;
    rout     = 1'b0;
    con_in   = 1'b0;
    pc_out   = 1'b0;
    y_in     = 1'b0;
    c_out    = 1'b0;
    alu_add  = 1'b0;
    z_in     = 1'b0;
    zlow_out = 1'b0;
    pc_in    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next = w_is_branch ? S_T3 : S_DONE;
        end
      end
      S_T3: begin
        if (!stall) begin
          gra    = 1'b1;
          rout   = 1'b1;
          con_in = 1'b1;
          w_next = S_T4;
        end
      end
      S_T4: begin
        if (!stall) begin
          pc_out = 1'b1;
          y_in   = 1'b1;
          w_next = (EARLY_EXIT && !con) ? S_DONE : S_T5;
        end
      end
      S_T5: begin
        if (!stall) begin
          c_out   = 1'b1;
          alu_add = 1'b1;
          z_in    = 1'b1;
          w_next  = S_T6;
        end
      end
      S_T6: begin
        if (!stall) begin
          zlow_out = 1'b1;
          pc_in    = r_taken;
          w_next   = S_DONE;
        end
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

endmodule
